fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
Read-side controller of the asynchronous FIFO, operating entirely in the rclk domain. It consumes the Gray-coded write pointer from the write domain, generates the read address for fifo_mem, and returns its own Gray read pointer to the write side. It pops entries into a registered valid/ready output stage and reports empty, almost-empty and occupancy.

Parameters:
ADDR_WIDTH, 4, memory address width; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
DATA_WIDTH, 32, data word width.
AEMPTY_THRESH, 2, raempty asserts when memory occupancy <= this value.

Ports:
rclk  in  1  read clock; all state on rising edge.
rrst_n  in  1  asynchronous active-low reset.
wptr_gray  in  ADDR_WIDTH+1  write pointer, Gray coded, registered in the wclk domain.
rptr_gray  out  ADDR_WIDTH+1  read pointer, Gray coded, registered; sent to the write domain.
raddr  out  ADDR_WIDTH  read address to fifo_mem; equals rbin[ADDR_WIDTH-1:0].
mem_rdata  in  DATA_WIDTH  combinational read data from fifo_mem at raddr.
rdata  out  DATA_WIDTH  output data register.
rvalid  out  1  rdata holds a valid word.
rready  in  1  consumer accepts rdata this cycle.
rempty  out  1  registered; memory holds no unread words (output register excluded).
raempty  out  1  registered; rlevel <= AEMPTY_THRESH.
rlevel  out  ADDR_WIDTH+1  registered memory occupancy, range 0..2**ADDR_WIDTH.

Behaviour:
- Reset (rrst_n low, asynchronous): wq1, wq2, rbin, rptr_gray, rdata and rlevel = 0; rvalid = 0; rempty = 1; raempty = 1. Release is synchronous to rclk by system construction. Both FIFO domains are reset together.
- Synchronizer: wq1 <= wptr_gray; wq2 <= wq1. Only wq2 is used downstream. wptr_gray is never decoded before it is synchronized.
- Pop condition: pop = ~rempty & (~rvalid | rready).
- On pop:
  - rdata <= mem_rdata
  - rvalid <= 1
  - rbin_next = rbin + 1, modulo 2**(ADDR_WIDTH+1)
- Without pop: if rvalid & rready, then rvalid <= 0. Otherwise rvalid and rdata hold.
- rdata must not change while rvalid & ~rready.
- Registered pointer update each cycle:
  - rbin <= rbin_next
  - rptr_gray <= rbin_next ^ (rbin_next >> 1)
- Registered flag update each cycle:
  - rempty <= (gray(rbin_next) == wq2)
  - rlevel <= gray2bin(wq2) - rbin_next, modulo 2**(ADDR_WIDTH+1)
  - raempty <= (rlevel_next <= AEMPTY_THRESH)
  - Invariant: rempty == (rlevel == 0) at all times.
- Latency:
  - A wptr_gray change launched before rclk edge E0 is captured at E0 (wq1) and reaches wq2 at E1.
  - rempty falls at E2.
  - rvalid rises at E3, with rdata = mem[raddr].
- Throughput: one word per rclk while rready stays high and the memory is non-empty.
- Wrap-around: the pointer MSB toggles every 2**ADDR_WIDTH reads. A full memory has rlevel = 2**ADDR_WIDTH with rempty = 0. raddr wraps from 2**ADDR_WIDTH-1 to 0.
- Simultaneous events:
  - Pop and a wq2 change in the same cycle: rempty and rlevel use the post-pop rbin_next and the current wq2.
  - Consume and pop in the same cycle: rvalid stays 1 and rdata takes the new word.
- Pessimism: rempty may remain high up to 2 cycles after a write (synchronizer delay). It never falls falsely.
- Reset mid-operation: all in-flight output data is discarded and flags return to reset values immediately, without waiting for rclk.

Decomposition:
- Package fifo_pkg: functions bin2gray and gray2bin parameterised by pointer width. The write-side controller shares the same pointer-width convention.
- Sub-module sync_2ff (WIDTH parameter, clk / rst_n / d / q, reset to 0). It is instantiated once for wptr_gray and reused by the write side for rptr_gray.

Test Plan:
1. Reset with rrst_n=0 and arbitrary wptr_gray -> rvalid=0, rempty=1, raempty=1, rlevel=0, rptr_gray=0, raddr=0, asserted asynchronously without any rclk edge.
2. Single write: wptr_gray 0->1 before E0, rready=1, mem[0]=32'hA5A5_0001 -> rempty falls at E2; rvalid=1 with rdata=32'hA5A5_0001 at E3; rptr_gray=1 and rempty=1 after E3; rvalid=0 after E4.
3. Backpressure: 3 words in memory, rready=0 for 5 cycles -> rvalid=1, rdata constant (first word), rlevel=2, raddr=1. Then rready=1 -> words 2 and 3 delivered on consecutive cycles.
4. Full-depth wrap: write pointer advanced to 16 (Gray 5'b11000) -> rlevel=16, rempty=0, raempty=0. Drain with rready=1 -> 16 words in order; raddr wraps 15->0; final rptr_gray=5'b11000, rempty=1, rlevel=0.
5. Almost-empty (AEMPTY_THRESH=2): occupancy 4 draining -> raempty=0 at rlevel 4 and 3, raempty=1 at rlevel 2, 1, 0.
6. Reset mid-drain with rlevel=6 and rvalid=1 -> all outputs at reset values immediately. After release with wptr_gray=0, rempty stays 1 and no spurious rvalid appears.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the asynchronous FIFO.
// Pointers of any width up to PTR_MAX bits are passed zero-extended.
package fifo_pkg;

    localparam int PTR_MAX = 32;

    typedef logic [PTR_MAX-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it; the zero
    // extension keeps this correct for any narrower pointer width.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = '0;
        for (int i = 0; i < PTR_MAX; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for Gray-coded pointers crossing clock domains.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: synchronizes the write
// pointer, pops memory words into a registered output stage, reports flags.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [ADDR_WIDTH:0]   wptr_gray,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  rempty,
    output logic                  raempty,
    output logic [ADDR_WIDTH:0]   rlevel
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0] wq2;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rbin_next;
    logic [PTR_W-1:0] rgray_next;
    logic [PTR_W-1:0] wbin_sync;
    logic [PTR_W-1:0] rlevel_next;
    logic             pop;

    sync_2ff #(
        .WIDTH(PTR_W)
    ) u_wptr_sync (
        .clk  (rclk),
        .rst_n(rrst_n),
        .d    (wptr_gray),
        .q    (wq2)
    );

    // Handshake: a word transfers on any rclk edge where rvalid & rready.
    // Once rvalid is high, rdata is frozen until that transfer happens; the
    // stage refills in the same cycle it is consumed, so a steady rready
    // drains one word per clock.
    always_comb begin
        pop         = ~rempty & (~rvalid | rready);
        rbin_next   = rbin + PTR_W'(pop);
        rgray_next  = PTR_W'(bin2gray(ptr_t'(rbin_next)));
        wbin_sync   = PTR_W'(gray2bin(ptr_t'(wq2)));
        rlevel_next = wbin_sync - rbin_next;
    end

    assign raddr = rbin[ADDR_WIDTH-1:0];

    // Flags see the post-pop pointer against the already-synchronized write
    // pointer, so they can lag a write but never report data that is absent.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin      <= '0;
            rptr_gray <= '0;
            rempty    <= 1'b1;
            raempty   <= 1'b1;
            rlevel    <= '0;
        end else begin
            rbin      <= rbin_next;
            rptr_gray <= rgray_next;
            rempty    <= (rgray_next == wq2);
            raempty   <= (rlevel_next <= AEMPTY_LVL);
            rlevel    <= rlevel_next;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (pop) begin
            rdata  <= mem_rdata;
            rvalid <= 1'b1;
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural fifo_mem and a
// bench-side write pointer; expected values are hand-computed per step.
module tb_fifo_rd_ctrl;

    logic        rclk;
    logic        rrst_n = 1'b1;
    logic [4:0]  wptr_gray;
    logic [4:0]  rptr_gray;
    logic [3:0]  raddr;
    logic [31:0] mem_rdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic        rempty;
    logic        raempty;
    logic [4:0]  rlevel;

    logic [31:0] mem [0:15];
    logic [4:0]  wbin;
    int          n_checks = 0;
    int          n_errors = 0;

    fifo_rd_ctrl #(
        .ADDR_WIDTH   (4),
        .DATA_WIDTH   (32),
        .AEMPTY_THRESH(2)
    ) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .wptr_gray(wptr_gray),
        .rptr_gray(rptr_gray),
        .raddr    (raddr),
        .mem_rdata(mem_rdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .rready   (rready),
        .rempty   (rempty),
        .raempty  (raempty),
        .rlevel   (rlevel)
    );

    assign mem_rdata = mem[raddr];

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Writer model: store words, then publish the advanced pointer in Gray.
    task automatic write_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wbin[3:0]] = base + 32'(i);
            wbin = wbin + 5'd1;
        end
        wptr_gray = wbin ^ (wbin >> 1);
    endtask

    task automatic do_reset();
        rrst_n    = 1'b0;
        rready    = 1'b0;
        wbin      = '0;
        wptr_gray = '0;
        tick();
        tick();
        rrst_n = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        wbin      = '0;
        rready    = 1'b0;
        wptr_gray = 5'b10110;

        // 1: asynchronous reset before any clock edge
        #2 rrst_n = 1'b0;
        #1;
        check_eq("rst_rvalid",  32'(rvalid),    32'd0);
        check_eq("rst_rempty",  32'(rempty),    32'd1);
        check_eq("rst_raempty", 32'(raempty),   32'd1);
        check_eq("rst_rlevel",  32'(rlevel),    32'd0);
        check_eq("rst_rptr",    32'(rptr_gray), 32'd0);
        check_eq("rst_raddr",   32'(raddr),     32'd0);
        tick();
        tick();
        check_eq("rst_hold_rempty", 32'(rempty), 32'd1);
        wptr_gray = '0;
        rrst_n    = 1'b1;
        tick();

        // 2: single write, latency to rempty fall and rvalid rise
        mem[0]    = 32'hA5A5_0001;
        wbin      = 5'd1;
        wptr_gray = 5'd1;
        rready    = 1'b1;
        tick();
        check_eq("t2_e0_rempty", 32'(rempty), 32'd1);
        tick();
        check_eq("t2_e1_rempty", 32'(rempty), 32'd1);
        tick();
        check_eq("t2_e2_rempty", 32'(rempty), 32'd0);
        check_eq("t2_e2_rvalid", 32'(rvalid), 32'd0);
        check_eq("t2_e2_rlevel", 32'(rlevel), 32'd1);
        tick();
        check_eq("t2_e3_rvalid", 32'(rvalid),    32'd1);
        check_eq("t2_e3_rdata",  rdata,          32'hA5A5_0001);
        check_eq("t2_e3_rptr",   32'(rptr_gray), 32'd1);
        check_eq("t2_e3_rempty", 32'(rempty),    32'd1);
        tick();
        check_eq("t2_e4_rvalid", 32'(rvalid), 32'd0);

        // 3: backpressure holds the first word
        do_reset();
        write_words(3, 32'hB000_0001);
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t3_hold_rvalid", 32'(rvalid), 32'd1);
            check_eq("t3_hold_rdata",  rdata,       32'hB000_0001);
            check_eq("t3_hold_rlevel", 32'(rlevel), 32'd2);
            check_eq("t3_hold_raddr",  32'(raddr),  32'd1);
        end
        check_eq("t3_hold_raempty", 32'(raempty), 32'd1);
        rready = 1'b1;
        tick();
        check_eq("t3_w2_rvalid", 32'(rvalid), 32'd1);
        check_eq("t3_w2_rdata",  rdata,       32'hB000_0002);
        tick();
        check_eq("t3_w3_rvalid", 32'(rvalid), 32'd1);
        check_eq("t3_w3_rdata",  rdata,       32'hB000_0003);
        tick();
        check_eq("t3_done_rvalid", 32'(rvalid), 32'd0);
        check_eq("t3_done_rempty", 32'(rempty), 32'd1);

        // 4: full depth, drain with address wrap
        do_reset();
        write_words(16, 32'hC000_0000);
        check_eq("t4_wptr_gray", 32'(wptr_gray), 32'b11000);
        tick();
        tick();
        tick();
        check_eq("t4_full_rlevel",  32'(rlevel),  32'd16);
        check_eq("t4_full_rempty",  32'(rempty),  32'd0);
        check_eq("t4_full_raempty", 32'(raempty), 32'd0);
        rready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_eq("t4_drain_rvalid", 32'(rvalid), 32'd1);
            check_eq("t4_drain_rdata",  rdata,       32'hC000_0000 + 32'(i));
            check_eq("t4_drain_raddr",  32'(raddr),  32'((i + 1) % 16));
        end
        tick();
        check_eq("t4_end_rvalid", 32'(rvalid),    32'd0);
        check_eq("t4_end_rptr",   32'(rptr_gray), 32'b11000);
        check_eq("t4_end_rempty", 32'(rempty),    32'd1);
        check_eq("t4_end_rlevel", 32'(rlevel),    32'd0);

        // 5: almost-empty threshold while draining 4 words
        rready = 1'b0;
        write_words(4, 32'hD000_0000);
        tick();
        tick();
        tick();
        check_eq("t5_l4_rlevel",  32'(rlevel),  32'd4);
        check_eq("t5_l4_raempty", 32'(raempty), 32'd0);
        tick();
        check_eq("t5_l3_rlevel",  32'(rlevel),  32'd3);
        check_eq("t5_l3_raempty", 32'(raempty), 32'd0);
        check_eq("t5_l3_rdata",   rdata,        32'hD000_0000);
        rready = 1'b1;
        tick();
        check_eq("t5_l2_rlevel",  32'(rlevel),  32'd2);
        check_eq("t5_l2_raempty", 32'(raempty), 32'd1);
        tick();
        check_eq("t5_l1_rlevel",  32'(rlevel),  32'd1);
        check_eq("t5_l1_raempty", 32'(raempty), 32'd1);
        tick();
        check_eq("t5_l0_rlevel",  32'(rlevel),  32'd0);
        check_eq("t5_l0_raempty", 32'(raempty), 32'd1);
        check_eq("t5_l0_rempty",  32'(rempty),  32'd1);
        check_eq("t5_l0_rdata",   rdata,        32'hD000_0003);
        tick();
        check_eq("t5_end_rvalid", 32'(rvalid), 32'd0);

        // 6: asynchronous reset mid-drain
        rready = 1'b0;
        write_words(7, 32'hE000_0000);
        tick();
        tick();
        tick();
        tick();
        check_eq("t6_pre_rlevel", 32'(rlevel), 32'd6);
        check_eq("t6_pre_rvalid", 32'(rvalid), 32'd1);
        #2;
        rrst_n    = 1'b0;
        wbin      = '0;
        wptr_gray = '0;
        #1;
        check_eq("t6_rst_rvalid",  32'(rvalid),    32'd0);
        check_eq("t6_rst_rdata",   rdata,          32'd0);
        check_eq("t6_rst_rempty",  32'(rempty),    32'd1);
        check_eq("t6_rst_raempty", 32'(raempty),   32'd1);
        check_eq("t6_rst_rlevel",  32'(rlevel),    32'd0);
        check_eq("t6_rst_rptr",    32'(rptr_gray), 32'd0);
        check_eq("t6_rst_raddr",   32'(raddr),     32'd0);
        tick();
        rrst_n = 1'b1;
        rready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t6_post_rempty", 32'(rempty), 32'd1);
            check_eq("t6_post_rvalid", 32'(rvalid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
